// File: rtl/lpc_reg_pkg.sv
// ---------------------------------------------------------------------------
// lpc_reg_pkg
//   Shared definitions for the LPC CPLD internal register file write path.
//   - LPC_NUM_REGS   : number of implemented register offsets (0x00-0x1F)
//   - LPC_UNLOCK_KEY : value written to the lock register to unlock it
//   - REG_*          : well-known register offsets
//   - lpc_wr_t       : one captured write {addr, data, valid}
//   - lpc_reg_byte   : helper that extracts register i from a flat bank
// ---------------------------------------------------------------------------
package lpc_reg_pkg;

  localparam int unsigned LPC_NUM_REGS   = 32;
  localparam logic [7:0]  LPC_UNLOCK_KEY = 8'hA5;

  localparam logic [7:0] REG_VERSION   = 8'h00;
  localparam logic [7:0] REG_BIOS_WDT  = 8'h01;
  localparam logic [7:0] REG_7SEG_SEL  = 8'h0E;
  localparam logic [7:0] REG_7SEG_DATA = 8'h0F;
  localparam logic [7:0] REG_LOCK      = 8'h1E;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
    logic       valid;
  } lpc_wr_t;

  // Register i of a flat 256-bit bank image.
  function automatic logic [7:0] lpc_reg_byte(input logic [255:0] flat, input int unsigned i);
    return flat[8*i +: 8];
  endfunction

endpackage

// File: rtl/lpc_wr_capture.sv
// ---------------------------------------------------------------------------
// lpc_wr_capture
//   First pipeline stage of the register write path. Registers the decoded
//   write {addr, data} when wr_strobe_i pulses and raises valid for exactly
//   the following cycle. Address/data hold their last captured value while
//   valid is low.
//
//   Handshake: wr_strobe_i is a one-cycle valid with no ready; the stage is
//   always able to accept, so a strobe every cycle is captured every cycle.
//
//   Ports
//     clk_i        : LPC clock
//     rst_i        : asynchronous reset, active-high (drops any capture)
//     wr_strobe_i  : one-cycle pulse, addr_i/data_i valid
//     addr_i       : register offset
//     data_i       : write data
//     wr_o         : captured write, valid for one cycle per strobe
// ---------------------------------------------------------------------------
module lpc_wr_capture
  import lpc_reg_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       wr_strobe_i,
  input  logic [7:0] addr_i,
  input  logic [7:0] data_i,
  output lpc_wr_t    wr_o
);

  lpc_wr_t wr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q <= '0;
    end else begin
      wr_q.valid <= wr_strobe_i;
      if (wr_strobe_i) begin
        wr_q.addr <= addr_i;
        wr_q.data <= data_i;
      end
    end
  end

  assign wr_o = wr_q;

endmodule

// File: rtl/lpc_reg_write.sv
// ---------------------------------------------------------------------------
// lpc_reg_write
//   Write side of the LPC CPLD internal register file (offsets 0x00-0x1F).
//   Decoded LPC I/O writes pass through a capture stage (lpc_wr_capture) and
//   are committed to the bank one cycle later. Each accepted write raises a
//   one-cycle pulse on WrPulse[addr]; each dropped write (out of range,
//   read-only, or write-protected) raises WrErr for one cycle instead.
//
//   Handshake: WrStrobe is a one-cycle valid with no ready. The pipeline
//   accepts one write per cycle forever, so nothing is ever back-pressured.
//
//   Ports
//     LpcClock : 33 MHz LPC clock
//     PciReset : asynchronous reset, active-high
//     WrStrobe : write completed, AddrReg/DataWr valid this cycle
//     AddrReg  : register offset (full 8-bit compare against NUM_REGS)
//     DataWr   : write data
//     HwSet    : sticky-set requests for W1C regs, bit 8i+b -> reg i bit b
//     RegFile  : flat register contents, reg i at [8i+7:8i]
//     WrPulse  : one-hot pulse on the register that accepted a write
//     WrErr    : pulse when a write is dropped
//
//   Build option: define LPC_WR_LOCK_EN to turn LOCK_ADDR into a lock flag
//   (locked after reset, 8'hA5 unlocks, anything else locks) that drops
//   writes to PROT_MASK registers while locked. Without it LOCK_ADDR is an
//   ordinary register and PROT_MASK has no effect.
// ---------------------------------------------------------------------------
module lpc_reg_write
  import lpc_reg_pkg::*;
#(
  parameter int unsigned   NUM_REGS   = LPC_NUM_REGS,
  parameter logic [7:0]    HW_VERSION = 8'h01,
  parameter logic [31:0]   RO_MASK    = 32'h1,
  parameter logic [31:0]   W1C_MASK   = 32'h0,
  parameter logic [255:0]  RESET_VAL  = 256'h0,
  parameter logic [7:0]    LOCK_ADDR  = REG_LOCK,
  parameter logic [31:0]   PROT_MASK  = 32'h2
) (
  input  logic         LpcClock,
  input  logic         PciReset,
  input  logic         WrStrobe,
  input  logic [7:0]   AddrReg,
  input  logic [7:0]   DataWr,
  input  logic [255:0] HwSet,
  output logic [255:0] RegFile,
  output logic [31:0]  WrPulse,
  output logic         WrErr
);

  // Reg 0 is the version register and can never be written or set.
  localparam logic [31:0] RO_EFF  = RO_MASK | 32'h1;
  localparam logic [31:0] W1C_EFF = W1C_MASK & ~32'h1;

  // ---------------------------------------------------------------------
  // Stage 1: capture
  // ---------------------------------------------------------------------
  lpc_wr_t s1;

  lpc_wr_capture u_capture (
    .clk_i       (LpcClock),
    .rst_i       (PciReset),
    .wr_strobe_i (WrStrobe),
    .addr_i      (AddrReg),
    .data_i      (DataWr),
    .wr_o        (s1)
  );

  // ---------------------------------------------------------------------
  // Stage 2: classify and commit
  // ---------------------------------------------------------------------
  logic [7:0]  bank_q [32];
  logic [7:0]  bank_d [32];
  logic [31:0] pulse_q, pulse_d;
  logic        err_q, err_d;
  logic        in_range;
  logic [4:0]  idx;

  // Full-width compare so 0x20-0xFF can never alias onto a low offset.
  assign in_range = (32'(s1.addr) < NUM_REGS);
  assign idx      = s1.addr[4:0];

`ifdef LPC_WR_LOCK_EN
  logic lock_q, lock_d;
`endif

  always_comb begin
    for (int i = 0; i < 32; i++) begin
      bank_d[i] = bank_q[i];
    end
    pulse_d = '0;
    err_d   = 1'b0;
`ifdef LPC_WR_LOCK_EN
    lock_d  = lock_q;
`endif

    if (s1.valid) begin
      if (!in_range) begin
        err_d = 1'b1;
      end
`ifdef LPC_WR_LOCK_EN
      // The lock register itself is always writable so software can unlock.
      else if (s1.addr == LOCK_ADDR) begin
        lock_d         = (s1.data != LPC_UNLOCK_KEY);
        pulse_d[idx]   = 1'b1;
      end
      // lock_q already reflects a lock write committed on the previous edge.
      else if (lock_q && PROT_MASK[idx]) begin
        err_d = 1'b1;
      end
`endif
      else if (RO_EFF[idx]) begin
        err_d = 1'b1;
      end else begin
        if (W1C_EFF[idx]) begin
          bank_d[idx] = bank_q[idx] & ~s1.data;
        end else begin
          bank_d[idx] = s1.data;
        end
        pulse_d[idx] = 1'b1;
      end
    end

    // Hardware sticky sets are applied after the write so a set and a
    // clear of the same bit in one cycle leaves the bit set.
    for (int i = 0; i < 32; i++) begin
      if (W1C_EFF[i] && (i < int'(NUM_REGS))) begin
        bank_d[i] = bank_d[i] | HwSet[8*i +: 8];
      end
    end
  end

  always_ff @(posedge LpcClock or posedge PciReset) begin
    if (PciReset) begin
      for (int i = 0; i < 32; i++) begin
        bank_q[i] <= (i == 0) ? HW_VERSION : RESET_VAL[8*i +: 8];
      end
      pulse_q <= '0;
      err_q   <= 1'b0;
`ifdef LPC_WR_LOCK_EN
      lock_q  <= 1'b1;
`endif
    end else begin
      for (int i = 0; i < 32; i++) begin
        bank_q[i] <= bank_d[i];
      end
      pulse_q <= pulse_d;
      err_q   <= err_d;
`ifdef LPC_WR_LOCK_EN
      lock_q  <= lock_d;
`endif
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  for (genvar g = 0; g < 32; g++) begin : g_regfile
    if (g >= int'(NUM_REGS)) begin : g_absent
      assign RegFile[8*g +: 8] = 8'h00;
    end else if (g == 0) begin : g_version
      assign RegFile[8*g +: 8] = HW_VERSION;
    end else begin : g_present
`ifdef LPC_WR_LOCK_EN
      assign RegFile[8*g +: 8] = (8'(g) == LOCK_ADDR) ? {7'd0, lock_q} : bank_q[g];
`else
      assign RegFile[8*g +: 8] = bank_q[g];
`endif
    end
  end

  assign WrPulse = pulse_q;
  assign WrErr   = err_q;

  // HwSet bits of non-W1C registers are intentionally ignored.
  logic unused_hwset;
  assign unused_hwset = ^HwSet;

`ifndef LPC_WR_LOCK_EN
  logic unused_lock_cfg;
  assign unused_lock_cfg = ^{PROT_MASK, LOCK_ADDR};
`endif

endmodule

// File: tb/tb_lpc_reg_write.sv
module tb_lpc_reg_write;
  import lpc_reg_pkg::*;

  // reg0 = EE (must be ignored), reg2 = 44 (RO), reg3 = F0 (W1C), reg5 = 3C
  localparam logic [255:0] RST_VAL = (256'hEE) | (256'h44 << 16) | (256'hF0 << 24) | (256'h3C << 40);

  logic         clk;
  logic         PciReset;
  logic         WrStrobe;
  logic [7:0]   AddrReg;
  logic [7:0]   DataWr;
  logic [255:0] HwSet;
  logic [255:0] RegFile;
  logic [31:0]  WrPulse;
  logic         WrErr;

  logic [255:0] exp_rf;
  int checks;
  int errors;

  lpc_reg_write #(
    .NUM_REGS   (32),
    .HW_VERSION (8'h01),
    .RO_MASK    (32'h0000_0004),
    .W1C_MASK   (32'h0000_0008),
    .RESET_VAL  (RST_VAL),
    .LOCK_ADDR  (REG_LOCK),
    .PROT_MASK  (32'h0000_0002)
  ) dut (
    .LpcClock (clk),
    .PciReset (PciReset),
    .WrStrobe (WrStrobe),
    .AddrReg  (AddrReg),
    .DataWr   (DataWr),
    .HwSet    (HwSet),
    .RegFile  (RegFile),
    .WrPulse  (WrPulse),
    .WrErr    (WrErr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic load_reset_exp();
    exp_rf = RST_VAL;
    exp_rf[7:0] = 8'h01;
`ifdef LPC_WR_LOCK_EN
    exp_rf[8*30 +: 8] = 8'h01;
`endif
  endtask

  // Called at posedge+1. Strobe in cycle N, commit visible during N+2.
  task automatic wr_cycle(input string tag, input logic [7:0] a, input logic [7:0] d,
                          input logic [31:0] exp_pulse, input logic exp_err,
                          input logic upd_en, input int upd_idx, input logic [7:0] upd_val);
    WrStrobe = 1'b1; AddrReg = a; DataWr = d;
    @(posedge clk); #1;
    WrStrobe = 1'b0;
    check_eq({tag, "/lat_pulse"}, 256'(WrPulse), 256'(0));
    check_eq({tag, "/lat_rf"}, RegFile, exp_rf);
    if (upd_en) exp_rf[8*upd_idx +: 8] = upd_val;
    @(posedge clk); #1;
    check_eq({tag, "/pulse"}, 256'(WrPulse), 256'(exp_pulse));
    check_eq({tag, "/err"}, 256'(WrErr), 256'(exp_err));
    check_eq({tag, "/rf"}, RegFile, exp_rf);
    @(posedge clk); #1;
    check_eq({tag, "/clr"}, 256'({WrErr, WrPulse}), 256'(0));
  endtask

  initial begin
    checks = 0; errors = 0;
    PciReset = 1'b1; WrStrobe = 1'b0; AddrReg = '0; DataWr = '0; HwSet = '0;
    load_reset_exp();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in/rf", RegFile, exp_rf);
    PciReset = 1'b0;
    @(posedge clk); #1;
    check_eq("rst/rf", RegFile, exp_rf);
    check_eq("rst/pulse", 256'(WrPulse), 256'(0));
    check_eq("rst/err", 256'(WrErr), 256'(0));

    // basic write to 7-seg data
    wr_cycle("w0F", REG_7SEG_DATA, 8'h5A, 32'h0000_8000, 1'b0, 1'b1, 15, 8'h5A);

    // dropped writes
    wr_cycle("ro_ver",  8'h00, 8'hFF, 32'h0, 1'b1, 1'b0, 0, 8'h00);
    wr_cycle("oor_25",  8'h25, 8'h11, 32'h0, 1'b1, 1'b0, 0, 8'h00);
    wr_cycle("oor_20",  8'h20, 8'h01, 32'h0, 1'b1, 1'b0, 0, 8'h00);
    wr_cycle("oor_FF",  8'hFF, 8'hAA, 32'h0, 1'b1, 1'b0, 0, 8'h00);
    wr_cycle("ro_r2",   8'h02, 8'h12, 32'h0, 1'b1, 1'b0, 0, 8'h00);
    wr_cycle("w1F",     8'h1F, 8'hC3, 32'h8000_0000, 1'b0, 1'b1, 31, 8'hC3);

    // W1C clear of 0x30 with hw set of bit 5 in the commit cycle: F0 -> E0
    WrStrobe = 1'b1; AddrReg = 8'h03; DataWr = 8'h30;
    @(posedge clk); #1;
    WrStrobe = 1'b0; HwSet[29] = 1'b1;
    @(posedge clk); #1;
    HwSet = '0;
    exp_rf[8*3 +: 8] = 8'hE0;
    check_eq("w1c_set/pulse", 256'(WrPulse), 256'(32'h8));
    check_eq("w1c_set/rf", RegFile, exp_rf);
    @(posedge clk); #1;

    // HwSet alone: W1C reg3 bit0 sets, non-W1C reg5 bit0 ignored
    HwSet[24] = 1'b1; HwSet[40] = 1'b1;
    @(posedge clk); #1;
    HwSet = '0;
    exp_rf[8*3 +: 8] = 8'hE1;
    check_eq("hwset/rf", RegFile, exp_rf);
    check_eq("hwset/pulse", 256'({WrErr, WrPulse}), 256'(0));

    wr_cycle("w1c_00", 8'h03, 8'h00, 32'h8, 1'b0, 1'b1, 3, 8'hE1);
    wr_cycle("w1c_81", 8'h03, 8'h81, 32'h8, 1'b0, 1'b1, 3, 8'h60);

    // back-to-back strobes
    WrStrobe = 1'b1; AddrReg = REG_7SEG_SEL; DataWr = 8'h01;
    @(posedge clk); #1;
    AddrReg = REG_7SEG_DATA; DataWr = 8'h02;
    @(posedge clk); #1;
    AddrReg = REG_7SEG_SEL; DataWr = 8'h03;
    check_eq("b2b/p0", 256'(WrPulse), 256'(32'h4000));
    @(posedge clk); #1;
    WrStrobe = 1'b0;
    check_eq("b2b/p1", 256'(WrPulse), 256'(32'h8000));
    @(posedge clk); #1;
    check_eq("b2b/p2", 256'(WrPulse), 256'(32'h4000));
    @(posedge clk); #1;
    exp_rf[8*14 +: 8] = 8'h03;
    exp_rf[8*15 +: 8] = 8'h02;
    check_eq("b2b/p3", 256'(WrPulse), 256'(0));
    check_eq("b2b/rf", RegFile, exp_rf);

`ifdef LPC_WR_LOCK_EN
    wr_cycle("lk_wdt",  REG_BIOS_WDT, 8'h77, 32'h0, 1'b1, 1'b0, 0, 8'h00);
    wr_cycle("lk_open", REG_LOCK, 8'hA5, 32'h4000_0000, 1'b0, 1'b1, 30, 8'h00);
    wr_cycle("lk_wdt2", REG_BIOS_WDT, 8'h77, 32'h2, 1'b0, 1'b1, 1, 8'h77);
    // relock then immediately write a protected reg: must be dropped
    WrStrobe = 1'b1; AddrReg = REG_LOCK; DataWr = 8'h00;
    @(posedge clk); #1;
    AddrReg = REG_BIOS_WDT; DataWr = 8'h55;
    @(posedge clk); #1;
    WrStrobe = 1'b0;
    exp_rf[8*30 +: 8] = 8'h01;
    check_eq("relock/pulse", 256'(WrPulse), 256'(32'h4000_0000));
    check_eq("relock/rf", RegFile, exp_rf);
    @(posedge clk); #1;
    check_eq("relock/err", 256'({WrErr, WrPulse}), 256'({1'b1, 32'h0}));
    check_eq("relock/rf2", RegFile, exp_rf);
    @(posedge clk); #1;
    wr_cycle("lk_open2", REG_LOCK, 8'hA5, 32'h4000_0000, 1'b0, 1'b1, 30, 8'h00);
`else
    wr_cycle("wdt",   REG_BIOS_WDT, 8'h77, 32'h2, 1'b0, 1'b1, 1, 8'h77);
    wr_cycle("r1E",   REG_LOCK, 8'h5A, 32'h4000_0000, 1'b0, 1'b1, 30, 8'h5A);
`endif

    // reset while a write is in the capture stage: write lost
    WrStrobe = 1'b1; AddrReg = 8'h05; DataWr = 8'h99;
    @(posedge clk); #1;
    WrStrobe = 1'b0;
    PciReset = 1'b1;
    #1;
    load_reset_exp();
    check_eq("midrst/rf", RegFile, exp_rf);
    repeat (2) @(posedge clk);
    #1;
    PciReset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("midrst/rf2", RegFile, exp_rf);
    check_eq("midrst/out", 256'({WrErr, WrPulse}), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
